alu_seq: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU.
- Operand width is set by WIDTH. Input and output use valid/ready handshakes, so the block can sit between pipeline stages of the datapath.
- Adds a persistent carry flag for multi-word chaining, corrected signed-overflow for subtraction, rotates and arithmetic shift, and an iterative shift-add unsigned multiplier with a double-width result.

---
 rtl/alu_seq_if.sv | 35 +++
 rtl/alu_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: the valid/ready request side
// (operands, opcode, carry select) and the registered result side with flags.
interface alu_seq_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       opcode;
   logic             cin;
   logic             use_cflag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             cout;
   logic             zero;
   logic             sign;
   logic             overflow;
   logic             cflag;
   logic             busy;

   modport master (
      output in_valid, a, b, opcode, cin, use_cflag, out_ready,
      input  in_ready, out_valid, result, result_hi, cout, zero, sign,
             overflow, cflag, busy
   );

   modport slave (
      input  in_valid, a, b, opcode, cin, use_cflag, out_ready,
      output in_ready, out_valid, result, result_hi, cout, zero, sign,
             overflow, cflag, busy
   );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, a persistent carry flag for
// multi-word chaining, and an iterative shift-add unsigned multiplier that
// produces a double-width product.
module alu_seq #(
   parameter int unsigned WIDTH = 8
) (
   input logic      clk,
   input logic      rst_n,
   alu_seq_if.slave bus
);

   localparam int unsigned M = WIDTH - 1;
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [6:0] CNT_LAST = 7'(WIDTH - 1);
   localparam logic [6:0] CNT_DONE = 7'(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;

   typedef enum logic [4:0] {
      OP_ADD = 5'h00, OP_SUB, OP_ADC, OP_SBC, OP_INC, OP_DEC, OP_NEG,
      OP_AND, OP_OR, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_NOT,
      OP_SHL, OP_SHR, OP_MUL, OP_ROL, OP_ROR, OP_ASR
   } op_t;

   state_t           state;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] result_hi_q;
   logic             cout_q;
   logic             zero_q;
   logic             sign_q;
   logic             ovf_q;
   logic             cflag_q;
   logic             busy_q;

   // multiplier working registers: acc holds the high partial product,
   // mplier shifts out consumed multiplier bits and collects the low word
   logic [WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0] mplier_q;
   logic [WIDTH-1:0] acc_q;
   logic [6:0]       cnt_q;
   logic [WIDTH:0]   mul_part;

   logic             in_ready;
   logic             accept;
   logic             c_sel;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] r;
   logic             co;
   logic             ov;
   logic             arith;

   // handshake: accept when idle, or when the held result is being consumed
   always_comb begin
      in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
      accept   = bus.in_valid && in_ready;
   end

   // single-cycle datapath: result, carry/borrow and overflow for the request
   always_comb begin
      c_sel = bus.use_cflag ? cflag_q : bus.cin;
      sum   = '0;
      r     = '0;
      co    = 1'b0;
      ov    = 1'b0;
      arith = 1'b0;
      case (bus.opcode)
         OP_ADD: begin
            sum   = {1'b0, bus.a} + {1'b0, bus.b};
            r     = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            ov    = (bus.a[M] ~^ bus.b[M]) & (bus.a[M] ^ r[M]);
            arith = 1'b1;
         end
         OP_SUB: begin
            sum   = {1'b0, bus.a} - {1'b0, bus.b};
            r     = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            ov    = (bus.a[M] ^ bus.b[M]) & (bus.a[M] ^ r[M]);
            arith = 1'b1;
         end
         OP_ADC: begin
            sum   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, c_sel};
            r     = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            ov    = (bus.a[M] ~^ bus.b[M]) & (bus.a[M] ^ r[M]);
            arith = 1'b1;
         end
         OP_SBC: begin
            sum   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, c_sel};
            r     = sum[WIDTH-1:0];
            co    = sum[WIDTH];
            ov    = (bus.a[M] ^ bus.b[M]) & (bus.a[M] ^ r[M]);
            arith = 1'b1;
         end
         OP_INC:  r = bus.a + ONE;
         OP_DEC:  r = bus.a - ONE;
         OP_NEG:  r = ~bus.a + ONE;
         OP_AND:  r = bus.a & bus.b;
         OP_OR:   r = bus.a | bus.b;
         OP_XOR:  r = bus.a ^ bus.b;
         OP_NAND: r = ~(bus.a & bus.b);
         OP_NOR:  r = ~(bus.a | bus.b);
         OP_XNOR: r = ~(bus.a ^ bus.b);
         OP_NOT:  r = ~bus.a;
         OP_SHL: begin
            r  = {bus.a[M-1:0], 1'b0};
            co = bus.a[M];
         end
         OP_SHR: begin
            r  = {1'b0, bus.a[M:1]};
            co = bus.a[0];
         end
         OP_ROL: begin
            r  = {bus.a[M-1:0], bus.a[M]};
            co = bus.a[M];
         end
         OP_ROR: begin
            r  = {bus.a[0], bus.a[M:1]};
            co = bus.a[0];
         end
         OP_ASR: begin
            r  = {bus.a[M], bus.a[M:1]};
            co = bus.a[0];
         end
         default: r = '0;
      endcase
   end

   // one shift-add step: conditionally add the multiplicand into the high word
   always_comb begin
      mul_part = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
   end

   // control FSM with registered result, flags, carry flag and busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         result_q    <= '0;
         result_hi_q <= '0;
         cout_q      <= 1'b0;
         zero_q      <= 1'b0;
         sign_q      <= 1'b0;
         ovf_q       <= 1'b0;
         cflag_q     <= 1'b0;
         busy_q      <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         case (state)
            IDLE, HOLD: begin
               if (accept) begin
                  if (bus.opcode == OP_MUL) begin
                     state    <= MUL;
                     busy_q   <= 1'b1;
                     mcand_q  <= bus.a;
                     mplier_q <= bus.b;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                  end else begin
                     state       <= HOLD;
                     result_q    <= r;
                     result_hi_q <= '0;
                     cout_q      <= co;
                     zero_q      <= (r == '0);
                     sign_q      <= r[M];
                     ovf_q       <= ov;
                     if (arith) begin
                        cflag_q <= co;
                     end
                  end
               end else if (state == HOLD && bus.out_ready) begin
                  state <= IDLE;
               end
            end
            MUL: begin
               // WIDTH step cycles, then one cycle to publish the product
               if (cnt_q != CNT_DONE) begin
                  acc_q    <= mul_part[WIDTH:1];
                  mplier_q <= {mul_part[0], mplier_q[WIDTH-1:1]};
                  cnt_q    <= cnt_q + 7'd1;
                  if (cnt_q == CNT_LAST) begin
                     busy_q <= 1'b0;
                  end
               end else begin
                  state       <= HOLD;
                  result_q    <= mplier_q;
                  result_hi_q <= acc_q;
                  cout_q      <= 1'b0;
                  zero_q      <= ({acc_q, mplier_q} == '0);
                  sign_q      <= mplier_q[M];
                  ovf_q       <= (acc_q != '0);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == HOLD);
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.cout      = cout_q;
   assign bus.zero      = zero_q;
   assign bus.sign      = sign_q;
   assign bus.overflow  = ovf_q;
   assign bus.cflag     = cflag_q;
   assign bus.busy      = busy_q;

endmodule
